// File: rtl/div6_req_sequencer_pkg.sv
// Shared types and constants for the two-port divider request sequencer.
//   W         : operand/result width, tied to the 6-bit array divider
//   CNT_W     : width of the settle counter (SETTLE_CYC is 1..15)
//   DBZ_Q     : quotient returned for a divide-by-zero request
//   seqState_t: sequencer state encoding (IDLE/SETTLE/RESP)
package div6_req_sequencer_pkg;

  localparam int unsigned W     = 6;
  localparam int unsigned CNT_W = 4;

  typedef logic [W-1:0] word_t;

  // Requester id: 0 or 1
  typedef logic reqId_t;

  localparam word_t DBZ_Q = 6'h3F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seqState_t;

  // Operand pair as presented by one requester
  typedef struct packed {
    word_t a;
    word_t b;
  } divOperands_t;

  // One-hot select for a requester id
  function automatic logic [1:0] oneHot2(input reqId_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/div6_req_sequencer_if.sv
// Request/response bus between the two calculator ports and the sequencer.
//   req_valid/req_ready : per-requester request handshake
//   req_a0/b0, a1/b1    : dividend/divisor of requester 0/1
//   rsp_valid/rsp_ready : per-requester response handshake (rsp_valid one-hot)
//   rsp_q/rsp_r/rsp_dbz : quotient, remainder, divide-by-zero flag
// master = requester side, slave = sequencer side.
interface div6_req_sequencer_if;
  import div6_req_sequencer_pkg::*;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  word_t      req_a0;
  word_t      req_b0;
  word_t      req_a1;
  word_t      req_b1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  word_t      rsp_q;
  word_t      rsp_r;
  logic       rsp_dbz;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz
  );

endinterface

// File: rtl/div6_req_sequencer_rr_arb2.sv
// Two-input round-robin arbiter, purely combinational.
//   req : request bits, bit i = requester i
//   ptr : preferred requester when both request
//   gnt : one-hot grant (zero when nobody requests)
module div6_req_sequencer_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/div6_req_sequencer.sv
// Shares one external 6-bit combinational divider between two requesters.
// Arbitrates round-robin, registers the operands onto the divider, waits
// SETTLE_CYC cycles for the multicycle path, captures Q/R and returns them
// to the granted requester. Divide-by-zero is answered without the divider.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : request/response interface (slave side)
//   div_a/div_b  : registered operands to the divider
//   div_q/div_r  : divider results (combinational from div_a/div_b)
//   busy         : high whenever the sequencer is not IDLE
// SETTLE_CYC is legal in 1..15.
module div6_req_sequencer
  import div6_req_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  div6_req_sequencer_if.slave bus,
  output word_t               div_a,
  output word_t               div_b,
  input  word_t               div_q,
  input  word_t               div_r,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  seqState_t        state;
  reqId_t           owner;
  reqId_t           rrPtr;
  reqId_t           gntId;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;
  logic             accept;
  divOperands_t     selOps;

  // Round-robin grant among the valid requesters
  div6_req_sequencer_rr_arb2 uArb (
    .req (bus.req_valid),
    .ptr (rrPtr),
    .gnt (gnt)
  );

  // Requests are only accepted in IDLE; ready follows the grant there
  assign bus.req_ready = (state == IDLE) ? gnt : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign gntId         = gnt[1];

  // Operand mux for the granted requester
  always_comb begin
    selOps = '{a: bus.req_a0, b: bus.req_b0};
    if (gntId) begin
      selOps = '{a: bus.req_a1, b: bus.req_b1};
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= 1'b0;
      rrPtr         <= 1'b0;
      cnt           <= '0;
      div_a         <= '0;
      div_b         <= '0;
      busy          <= 1'b0;
      bus.rsp_valid <= 2'b00;
      bus.rsp_q     <= '0;
      bus.rsp_r     <= '0;
      bus.rsp_dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= gntId;
            rrPtr <= ~gntId;
            busy  <= 1'b1;
            if (selOps.b != '0) begin
              div_a <= selOps.a;
              div_b <= selOps.b;
              cnt   <= CNT_INIT;
              state <= SETTLE;
            end else begin
              // Divide-by-zero: answer directly, divider operands untouched
              bus.rsp_q     <= DBZ_Q;
              bus.rsp_r     <= selOps.a;
              bus.rsp_dbz   <= 1'b1;
              bus.rsp_valid <= oneHot2(gntId);
              state         <= RESP;
            end
          end
        end

        SETTLE: begin
          if (cnt == '0) begin
            bus.rsp_q     <= div_q;
            bus.rsp_r     <= div_r;
            bus.rsp_dbz   <= 1'b0;
            bus.rsp_valid <= oneHot2(owner);
            state         <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RESP: begin
          // Only the owner's ready completes the response
          if (bus.rsp_ready[owner]) begin
            bus.rsp_valid <= 2'b00;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          bus.rsp_valid <= 2'b00;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div6_req_sequencer.sv
// Bench for div6_req_sequencer: three instances (SETTLE_CYC = 2, 1, 15),
// each wrapped with a behavioural divider, driven by directed and random
// operations and checked against a reference model of the request rules.
module tb_div6_req_sequencer;

  localparam int unsigned NINST = 3;

  logic       clk = 1'b0;
  logic       rstN;

  logic [1:0] reqValid [NINST];
  logic [1:0] rspReady [NINST];
  logic [5:0] reqA     [NINST][2];
  logic [5:0] reqB     [NINST][2];

  logic [1:0] reqReady [NINST];
  logic [1:0] rspValid [NINST];
  logic [5:0] rspQ     [NINST];
  logic [5:0] rspR     [NINST];
  logic       rspDbz   [NINST];
  logic [5:0] divA     [NINST];
  logic [5:0] divB     [NINST];
  logic       busy     [NINST];

  int checks = 0;
  int errors = 0;

  // Reference model state: preferred requester and last divider operands
  int         expPref [NINST];
  logic [5:0] mDivA   [NINST];
  logic [5:0] mDivB   [NINST];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : gInst
    localparam int unsigned SC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    div6_req_sequencer_if bus ();
    logic [5:0] dq;
    logic [5:0] dr;

    assign bus.req_valid = reqValid[g];
    assign bus.req_a0    = reqA[g][0];
    assign bus.req_b0    = reqB[g][0];
    assign bus.req_a1    = reqA[g][1];
    assign bus.req_b1    = reqB[g][1];
    assign bus.rsp_ready = rspReady[g];
    assign reqReady[g]   = bus.req_ready;
    assign rspValid[g]   = bus.rsp_valid;
    assign rspQ[g]       = bus.rsp_q;
    assign rspR[g]       = bus.rsp_r;
    assign rspDbz[g]     = bus.rsp_dbz;

    // Behavioural stand-in for the array divider
    assign dq = (divB[g] == 6'd0) ? 6'h3F : 6'(divA[g] / divB[g]);
    assign dr = (divB[g] == 6'd0) ? divA[g] : 6'(divA[g] % divB[g]);

    div6_req_sequencer #(.SETTLE_CYC(SC)) dut (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (bus),
      .div_a (divA[g]),
      .div_b (divB[g]),
      .div_q (dq),
      .div_r (dr),
      .busy  (busy[g])
    );
  end

  function automatic int scOf(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic logic [1:0] oh(input int who);
    return (who == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after the accept edge; follows the op to completion
  task automatic waitResp(input int k, input int who, input logic [5:0] a,
                          input logic [5:0] b, input int hold, input bit keepReq);
    int n;
    int lat;
    logic [5:0] eq;
    logic [5:0] er;
    lat = (b == 6'd0) ? 1 : scOf(k) + 1;
    eq  = (b == 6'd0) ? 6'h3F : 6'(a / b);
    er  = (b == 6'd0) ? a : 6'(a % b);
    if (b != 6'd0) begin
      mDivA[k] = a;
      mDivB[k] = b;
    end
    n = 1;
    while (rspValid[k] == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency%0d", k), n, lat);
    chk($sformatf("rsp_valid%0d", k), rspValid[k], oh(who));
    chk($sformatf("rsp_q%0d a=%0d b=%0d", k, a, b), rspQ[k], eq);
    chk($sformatf("rsp_r%0d a=%0d b=%0d", k, a, b), rspR[k], er);
    chk($sformatf("rsp_dbz%0d", k), rspDbz[k], (b == 6'd0));
    chk($sformatf("busy_resp%0d", k), busy[k], 1'b1);
    chk($sformatf("div_a%0d", k), divA[k], mDivA[k]);
    chk($sformatf("div_b%0d", k), divB[k], mDivB[k]);
    for (int i = 0; i < hold; i++) begin
      if (!keepReq) begin
        reqValid[k]   = 2'b11;
        reqA[k][0]    = 6'($urandom);
        reqB[k][0]    = 6'($urandom);
        reqA[k][1]    = 6'($urandom);
        reqB[k][1]    = 6'($urandom);
      end
      rspReady[k] = oh(1 - who);
      @(negedge clk);
      chk("hold_valid", rspValid[k], oh(who));
      chk("hold_q", rspQ[k], eq);
      chk("hold_r", rspR[k], er);
      chk("hold_dbz", rspDbz[k], (b == 6'd0));
      chk("hold_req_ready", reqReady[k], 2'b00);
      chk("hold_busy", busy[k], 1'b1);
    end
    if (!keepReq) reqValid[k] = 2'b00;
    rspReady[k] = oh(who) | 2'($urandom);
    @(negedge clk);
    rspReady[k] = 2'b00;
    chk("ack_valid", rspValid[k], 2'b00);
    chk("ack_busy", busy[k], 1'b0);
    expPref[k] = 1 - who;
  endtask

  // Single-requester operation on an idle instance, called at a negedge
  task automatic runOp(input int k, input int who, input logic [5:0] a,
                       input logic [5:0] b, input int hold);
    reqA[k][who]     = a;
    reqB[k][who]     = b;
    reqValid[k][who] = 1'b1;
    #1;
    chk("req_ready", reqReady[k], oh(who));
    chk("busy_idle", busy[k], 1'b0);
    @(negedge clk);
    reqValid[k][who] = 1'b0;
    reqA[k][who]     = 6'($urandom);
    reqB[k][who]     = 6'($urandom);
    waitResp(k, who, a, b, hold, 1'b0);
  endtask

  initial begin
    rstN = 1'b0;
    for (int k = 0; k < NINST; k++) begin
      reqValid[k] = 2'b00;
      rspReady[k] = 2'b00;
      reqA[k][0] = '0; reqA[k][1] = '0;
      reqB[k][0] = '0; reqB[k][1] = '0;
      expPref[k] = 0;
      mDivA[k] = '0;
      mDivB[k] = '0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    for (int k = 0; k < NINST; k++) begin
      chk($sformatf("rst_rsp_valid%0d", k), rspValid[k], 2'b00);
      chk($sformatf("rst_busy%0d", k), busy[k], 1'b0);
      chk($sformatf("rst_q%0d", k), rspQ[k], 6'd0);
      chk($sformatf("rst_r%0d", k), rspR[k], 6'd0);
      chk($sformatf("rst_dbz%0d", k), rspDbz[k], 1'b0);
      chk($sformatf("rst_div_a%0d", k), divA[k], 6'd0);
      chk($sformatf("rst_div_b%0d", k), divB[k], 6'd0);
    end
    rstN = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NINST; k++) chk("idle_req_ready", reqReady[k], 2'b00);

    // Basic divides and edge operands
    runOp(0, 0, 6'd45, 6'd7, 0);
    runOp(0, 0, 6'd63, 6'd1, 1);
    runOp(0, 1, 6'd5, 6'd63, 0);

    // Divide-by-zero bypasses the divider
    runOp(0, 1, 6'd5, 6'd0, 0);

    // Both requesters continuously valid: grants alternate
    reqA[0][0] = 6'd20; reqB[0][0] = 6'd3;
    reqA[0][1] = 6'd17; reqB[0][1] = 6'd4;
    reqValid[0] = 2'b11;
    for (int op = 0; op < 4; op++) begin
      int g;
      g = expPref[0];
      #1;
      chk("fair_order", g, op % 2);
      chk("fair_grant", reqReady[0], oh(g));
      @(negedge clk);
      waitResp(0, g, reqA[0][g], reqB[0][g], op, 1'b1);
    end
    reqValid[0] = 2'b00;

    // Response back-pressure for 5 cycles
    runOp(0, 0, 6'd33, 6'd5, 5);

    // Reset during SETTLE aborts the operation
    reqA[0][0] = 6'd33; reqB[0][0] = 6'd4; reqValid[0] = 2'b01;
    @(negedge clk);
    reqValid[0] = 2'b00;
    chk("pre_rst_busy", busy[0], 1'b1);
    rstN = 1'b0;
    #1;
    chk("arst_rsp_valid", rspValid[0], 2'b00);
    chk("arst_busy", busy[0], 1'b0);
    chk("arst_div_a", divA[0], 6'd0);
    chk("arst_div_b", divB[0], 6'd0);
    chk("arst_q", rspQ[0], 6'd0);
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < NINST; k++) begin
      expPref[k] = 0;
      mDivA[k] = '0;
      mDivB[k] = '0;
    end
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_rsp", rspValid[0], 2'b00);
    end
    runOp(0, 0, 6'd12, 6'd5, 0);

    // Random traffic on the SETTLE_CYC=2 instance, including zero divisors
    repeat (200) begin
      int who;
      logic [5:0] a;
      logic [5:0] b;
      who = int'($urandom_range(0, 1));
      a   = 6'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      runOp(0, who, a, b, int'($urandom_range(0, 3)));
    end

    // Full nonzero operand sweep on the SETTLE_CYC=1 instance
    for (int a = 0; a < 64; a++) begin
      for (int b = 1; b < 64; b++) begin
        runOp(1, int'($urandom_range(0, 1)), 6'(a), 6'(b), 0);
      end
    end

    // Random nonzero operands on the SETTLE_CYC=15 instance
    repeat (150) begin
      runOp(2, int'($urandom_range(0, 1)), 6'($urandom),
            6'($urandom_range(1, 63)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
